// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the serial SRAM controller and the image kernels that
// drive it: job opcodes, FSM state encodings, image size constants and a small
// opcode helper.
package sram_ctrl_pkg;

  // Job opcodes on the kernel interface. These are also the SPI instruction
  // bytes of a 23LC1024-style SRAM.
  localparam logic [7:0] INST_NONE  = 8'h00;
  localparam logic [7:0] INST_WRITE = 8'h02;
  localparam logic [7:0] INST_READ  = 8'h03;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_ADDR = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // Frame sizes the kernels use for their byte_length requests.
  localparam int unsigned IMG_WIDTH      = 256;
  localparam int unsigned IMG_HEIGHT     = 256;
  localparam int unsigned IMG_BYTES_GRAY = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned IMG_BYTES_RGB  = 3 * IMG_BYTES_GRAY;

  function automatic logic is_job(input logic [7:0] op);
    return (op == INST_WRITE) || (op == INST_READ);
  endfunction

endpackage

// File: rtl/spi_phase_gen.sv
// SPI bit-clock generator.
// Divides clk into sck half-periods of HALF_DIV cycles while en is high; holds
// sck low and restarts at the beginning of phase L whenever en is low.
//   clk, rst_n : system clock, async active-low reset
//   en         : run the bit clock
//   sck        : SPI clock (mode 0, low in phase L, high in phase H)
//   phase_l    : first cycle of a bit period (phase L), where mosi changes
//   phase_h    : last cycle of a bit period (phase H), where miso is sampled
module spi_phase_gen #(
  parameter int unsigned HALF_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sck,
  output logic phase_l,
  output logic phase_h
);

  localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt;
  logic          ph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_LOAD;
      ph  <= 1'b0;
    end else if (!en) begin
      cnt <= CNT_LOAD;
      ph  <= 1'b0;
    end else if (cnt == '0) begin
      cnt <= CNT_LOAD;
      ph  <= ~ph;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign sck     = ph;
  assign phase_l = en && !ph && (cnt == CNT_LOAD);
  assign phase_h = en && ph && (cnt == '0);

endmodule

// File: rtl/spi_sram_controller.sv
// Serial SRAM job responder: turns one kernel job (inst/address/byte_length)
// into a single sequential-mode SPI transaction and streams the data one bit
// per io_valid pulse, MSB first.
//   clk, rst_n              : system clock, async active-low reset
//   inst                    : job opcode (2 = WRITE, 3 = READ, others ignored)
//   address, byte_length    : job parameters, captured at accept
//   write_in                : write data bit answering the last io_valid
//   mem_out, io_valid       : read data bit / per-bit strobe
//   rw_done, busy           : job completion pulse / job in progress
//   sram_sck, sram_cs_n,
//   sram_mosi, sram_miso    : SPI mode-0 pins to the SRAM
//
// state | meaning
// IDLE  | waiting for a job opcode
// CMD   | shifting the 8-bit instruction (or a one-cycle pass for length 0)
// ADDR  | shifting the ADDR_W-bit start address
// DATA  | byte_length*8 data bits
// DONE  | cs_n high, rw_done pulse
module spi_sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned LEN_W    = 24,
  parameter int unsigned HALF_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        inst,
  input  logic [ADDR_W-1:0] address,
  input  logic [LEN_W-1:0]  byte_length,
  input  logic              write_in,
  output logic              mem_out,
  output logic              io_valid,
  output logic              rw_done,
  output logic              busy,
  output logic              sram_sck,
  output logic              sram_cs_n,
  output logic              sram_mosi,
  input  logic              sram_miso
);

  localparam int unsigned SR_W = 8 + ADDR_W;
  localparam int unsigned BC_W = LEN_W + 3;

  state_t            state;
  logic [SR_W-1:0]   sreg;
  logic [BC_W-1:0]   bit_cnt;
  logic [LEN_W-1:0]  len_q;
  logic              wr_q;
  logic              skip_q;
  logic              wbit_q;
  logic              rd_valid_q;
  logic              rd_bit_q;
  logic              xfer;
  logic              phase_l;
  logic              phase_h;
  logic              bit_tc;
  logic              wr_req;

  // A zero-length job is flagged at accept and resolved one cycle later in
  // CMD, so the length compare never sits on the accept path and the job
  // still shows busy for two cycles without touching the bus.
  assign xfer   = ((state == ST_CMD) || (state == ST_ADDR) || (state == ST_DATA)) && !skip_q;
  assign bit_tc = (bit_cnt == '0);

  spi_phase_gen #(.HALF_DIV(HALF_DIV)) u_phase (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (xfer),
    .sck     (sram_sck),
    .phase_l (phase_l),
    .phase_h (phase_h)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      len_q      <= '0;
      wr_q       <= 1'b0;
      skip_q     <= 1'b0;
      wbit_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_bit_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_bit_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (is_job(inst)) begin
            state   <= ST_CMD;
            sreg    <= {inst, address};
            len_q   <= byte_length;
            wr_q    <= (inst == INST_WRITE);
            skip_q  <= (byte_length == '0);
            bit_cnt <= BC_W'(7);
          end
        end
        ST_CMD: begin
          if (skip_q) begin
            state <= ST_DONE;
          end else if (phase_h) begin
            sreg <= {sreg[SR_W-2:0], 1'b0};
            if (bit_tc) begin
              state   <= ST_ADDR;
              bit_cnt <= BC_W'(ADDR_W - 1);
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_ADDR: begin
          if (phase_h) begin
            sreg <= {sreg[SR_W-2:0], 1'b0};
            if (bit_tc) begin
              state   <= ST_DATA;
              bit_cnt <= {len_q, 3'b000} - 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (wr_q && phase_l) begin
            wbit_q <= write_in;
          end
          if (phase_h) begin
            if (!wr_q) begin
              rd_valid_q <= 1'b1;
              rd_bit_q   <= sram_miso;
            end
            if (bit_tc) begin
              state <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          skip_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Write bits are requested one bit ahead: the pulse lands in the H cycle
  // before the bit, and the answer is passed straight to mosi in the first L
  // cycle, then held from wbit_q for the rest of the bit.
  assign wr_req = wr_q && phase_h &&
                  (((state == ST_ADDR) && bit_tc) || ((state == ST_DATA) && !bit_tc));

  always_comb begin
    sram_mosi = 1'b0;
    if (xfer) begin
      case (state)
        ST_CMD, ST_ADDR: sram_mosi = sreg[SR_W-1];
        ST_DATA:         sram_mosi = wr_q && (phase_l ? write_in : wbit_q);
        default:         sram_mosi = 1'b0;
      endcase
    end
  end

  assign io_valid  = rd_valid_q || wr_req;
  assign mem_out   = rd_bit_q;
  assign rw_done   = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign sram_cs_n = !xfer;

endmodule

// File: tb/tb_spi_sram_controller.sv
module tb_spi_sram_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] inst_d [2];
  logic [23:0] addr_d [2];
  logic [23:0] len_d [2];
  logic [1:0] write_in = 2'b00;
  logic [1:0] miso = 2'b00;
  logic [1:0] mem_out, io_valid, rw_done, busy, sck, cs_n, mosi;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spi_sram_controller #(.ADDR_W(24), .LEN_W(24), .HALF_DIV(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .inst(inst_d[0]), .address(addr_d[0]),
    .byte_length(len_d[0]), .write_in(write_in[0]), .mem_out(mem_out[0]),
    .io_valid(io_valid[0]), .rw_done(rw_done[0]), .busy(busy[0]),
    .sram_sck(sck[0]), .sram_cs_n(cs_n[0]), .sram_mosi(mosi[0]), .sram_miso(miso[0])
  );

  spi_sram_controller #(.ADDR_W(24), .LEN_W(24), .HALF_DIV(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .inst(inst_d[1]), .address(addr_d[1]),
    .byte_length(len_d[1]), .write_in(write_in[1]), .mem_out(mem_out[1]),
    .io_valid(io_valid[1]), .rw_done(rw_done[1]), .busy(busy[1]),
    .sram_sck(sck[1]), .sram_cs_n(cs_n[1]), .sram_mosi(mosi[1]), .sram_miso(miso[1])
  );

  // SRAM models and bus monitors for both instances (single process).
  logic [7:0] rd_mem [2][4];
  logic [7:0] wr_byte [2];
  logic [7:0] rx [2][8];
  logic [7:0] cur [2];
  logic [15:0] rdbits [2];
  int rx_n [2], bitn [2], sck_rises [2], cs_low [2], busy_cnt [2];
  int done_cnt [2], done_iv [2], done_after_cs [2], vcnt [2], gap_bad [2];
  int last_iv [2], mo_hi [2];
  logic [1:0] prev_sck = 2'b00;
  logic [1:0] prev_cs = 2'b11;
  int cyc = 0;
  int clr_req = 0;
  int clr_seen = -1;

  always @(negedge clk) begin
    int idx;
    int k;
    int exp_gap;
    if (clr_seen != clr_req) begin
      for (int g = 0; g < 2; g++) begin
        rx_n[g] = 0; sck_rises[g] = 0; cs_low[g] = 0; busy_cnt[g] = 0;
        done_cnt[g] = 0; done_iv[g] = 0; done_after_cs[g] = 0; vcnt[g] = 0;
        gap_bad[g] = 0; last_iv[g] = 0; mo_hi[g] = 0; rdbits[g] = '0; cur[g] = '0;
        for (int b = 0; b < 8; b++) rx[g][b] = '0;
      end
      clr_seen = clr_req;
    end
    cyc++;
    for (int g = 0; g < 2; g++) begin
      exp_gap = (g == 0) ? 2 : 6;
      if (!cs_n[g]) cs_low[g]++;
      if (busy[g]) busy_cnt[g]++;
      if (mem_out[g]) mo_hi[g]++;
      if (rw_done[g]) begin
        done_cnt[g]++;
        if (io_valid[g]) done_iv[g]++;
        if (cs_n[g] && !prev_cs[g]) done_after_cs[g]++;
      end
      if (io_valid[g]) begin
        if (vcnt[g] > 0 && (cyc - last_iv[g]) != exp_gap) gap_bad[g]++;
        last_iv[g] = cyc;
        rdbits[g] = {rdbits[g][14:0], mem_out[g]};
        write_in[g] = wr_byte[g][7 - (vcnt[g] % 8)];
        vcnt[g]++;
      end
      if (sck[g] && !prev_sck[g]) begin
        sck_rises[g]++;
        if (!cs_n[g]) begin
          idx = bitn[g];
          cur[g] = {cur[g][6:0], mosi[g]};
          if (idx % 8 == 7 && rx_n[g] < 8) begin
            rx[g][rx_n[g]] = cur[g];
            rx_n[g]++;
          end
          if (idx >= 32 && rx[g][0] == 8'h03) begin
            k = idx - 32;
            miso[g] = rd_mem[g][(k / 8) % 4][7 - (k % 8)];
          end
          bitn[g]++;
        end
      end
      if (cs_n[g]) begin
        bitn[g] = 0;
        miso[g] = 1'b0;
      end
      prev_sck[g] = sck[g];
      prev_cs[g]  = cs_n[g];
    end
  end

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats();
    clr_req++;
    tick();
  endtask

  task automatic run_job(input int g, input logic [7:0] op, input logic [23:0] a,
                         input logic [23:0] l, input int budget, output int got);
    clear_stats();
    inst_d[g] = op;
    addr_d[g] = a;
    len_d[g]  = l;
    tick();
    inst_d[g] = 8'h00;
    got = 0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (done_cnt[g] != 0) begin
        got = 1;
        break;
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    for (int g = 0; g < 2; g++) begin
      inst_d[g] = 8'h00; addr_d[g] = '0; len_d[g] = '0; wr_byte[g] = '0;
      for (int b = 0; b < 4; b++) rd_mem[g][b] = '0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // outputs {cs_n, sck, busy, rw_done, io_valid, mem_out, mosi}
    chk_val("reset_outs0", {cs_n[0], sck[0], busy[0], rw_done[0], io_valid[0], mem_out[0], mosi[0]}, 7'b1000000);
    chk_val("reset_outs1", {cs_n[1], sck[1], busy[1], rw_done[1], io_valid[1], mem_out[1], mosi[1]}, 7'b1000000);

    // READ 0x000010, 2 bytes
    rd_mem[0][0] = 8'hA5; rd_mem[0][1] = 8'h3C;
    run_job(0, 8'h03, 24'h000010, 24'd2, 400, got);
    chk_val("read_done_seen", got, 1);
    chk_val("read_cmd_addr", {rx[0][0], rx[0][1], rx[0][2], rx[0][3]}, 32'h03000010);
    chk_val("read_valid_cnt", vcnt[0], 16);
    chk_val("read_data", rdbits[0], 16'hA53C);
    chk_val("read_done_cnt", done_cnt[0], 1);
    chk_val("read_cs_low", cs_low[0], 96);
    chk_val("read_last_iv_with_done", done_iv[0], 1);
    chk_val("read_busy_cycles", busy_cnt[0], 97);
    chk_val("read_iv_gaps", gap_bad[0], 0);

    // WRITE 0x01FFFF, 1 byte 0xC3
    wr_byte[0] = 8'hC3;
    run_job(0, 8'h02, 24'h01FFFF, 24'd1, 400, got);
    chk_val("write_done_seen", got, 1);
    chk_val("write_rx", {rx[0][0], rx[0][1], rx[0][2], rx[0][3], rx[0][4]}, 40'h0201FFFFC3);
    chk_val("write_valid_cnt", vcnt[0], 8);
    chk_val("write_done_after_cs", done_after_cs[0], 1);
    chk_val("write_mem_out_quiet", mo_hi[0], 0);
    chk_val("write_cs_low", cs_low[0], 80);

    // zero-length READ
    run_job(0, 8'h03, 24'h000100, 24'd0, 20, got);
    chk_val("zlen_done_cnt", done_cnt[0], 1);
    chk_val("zlen_sck_rises", sck_rises[0], 0);
    chk_val("zlen_cs_low", cs_low[0], 0);
    chk_val("zlen_busy_cycles", busy_cnt[0], 2);

    // illegal opcode then none
    clear_stats();
    inst_d[0] = 8'h07;
    repeat (3) tick();
    inst_d[0] = 8'h00;
    repeat (5) tick();
    chk_val("bad_op_busy", busy_cnt[0], 0);
    chk_val("bad_op_cs_low", cs_low[0], 0);
    chk_val("bad_op_done", done_cnt[0], 0);

    // reset during the 5th address bit of a READ
    clear_stats();
    inst_d[0] = 8'h03; addr_d[0] = 24'h000040; len_d[0] = 24'd2;
    tick();
    inst_d[0] = 8'h00;
    got = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (bitn[0] == 13) begin
        got = 1;
        break;
      end
    end
    chk_val("rst_mid_reached", got, 1);
    chk_val("rst_mid_sck_high_before", sck[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk_val("rst_mid_cs_sck", {cs_n[0], sck[0]}, 2'b10);
    repeat (4) tick();
    chk_val("rst_mid_no_done", done_cnt[0], 0);
    rst_n = 1'b1;
    tick();
    rd_mem[0][0] = 8'h5A;
    run_job(0, 8'h03, 24'h000200, 24'd1, 400, got);
    chk_val("post_rst_done", done_cnt[0], 1);
    chk_val("post_rst_data", rdbits[0], 16'h005A);

    // HALF_DIV=3 READ, 1 byte
    rd_mem[1][0] = 8'h96;
    run_job(1, 8'h03, 24'h000123, 24'd1, 800, got);
    chk_val("hd3_done_seen", got, 1);
    chk_val("hd3_cmd_addr", {rx[1][0], rx[1][1], rx[1][2], rx[1][3]}, 32'h03000123);
    chk_val("hd3_valid_cnt", vcnt[1], 8);
    chk_val("hd3_data", rdbits[1], 16'h0096);
    chk_val("hd3_iv_gaps", gap_bad[1], 0);
    chk_val("hd3_sck_rises", sck_rises[1], 40);
    chk_val("hd3_cs_low", cs_low[1], 240);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
